ram_wb_dp_be: RTL and testbench



---
 rtl/ram_wb_pkg.sv | 30 +++
 rtl/ram_wb_dp_be_port.sv | 105 ++++++++++
 rtl/ram_wb_dp_be.sv | 143 ++++++++++++++
 tb/tb_ram_wb_dp_be.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ram_wb_pkg.sv
// Shared constants and byte-lane helpers for the dual-port Wishbone RAM core.
package ram_wb_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_DW    = 256;
    localparam int MAX_LANES = MAX_DW / BYTE_W;

    function automatic int lanes(input int dw);
        return dw / BYTE_W;
    endfunction

    // Per-byte-lane mux on a maximal-width word; callers zero-extend and slice.
    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0]    old_w,
        input logic [MAX_DW-1:0]    new_w,
        input logic [MAX_LANES-1:0] sel
    );
        logic [MAX_DW-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (sel[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
            end else begin
                res[i*BYTE_W +: BYTE_W] = old_w[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_wb_dp_be_port.sv
// One read port: read-during-write forwarding, valid tracking and optional output stage.
module ram_wb_dp_be_port
    import ram_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RDW_NEW    = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DATA_WIDTH-1:0]         rd_word,
    input  logic [DATA_WIDTH-1:0]         own_d,
    input  logic [lanes(DATA_WIDTH)-1:0]  own_sel,
    input  logic [DATA_WIDTH-1:0]         oth_d,
    input  logic [lanes(DATA_WIDTH)-1:0]  oth_sel,
    output logic [DATA_WIDTH-1:0]         q,
    output logic                          vld
);

    localparam int NL = lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] data_s;
    logic [MAX_DW-1:0]     old_x_s, own_x_s, oth_x_s, merged_x_s;
    logic [MAX_LANES-1:0]  own_sel_x_s, oth_sel_x_s;
    logic [DATA_WIDTH-1:0] q1_d, q1_q;
    logic                  v1_d, v1_q;

    // Forwarding: the committed (winner-masked) lanes of both ports overlay the old word.
    always_comb begin
        old_x_s     = '0;
        own_x_s     = '0;
        oth_x_s     = '0;
        own_sel_x_s = '0;
        oth_sel_x_s = '0;
        old_x_s[DATA_WIDTH-1:0] = rd_word;
        own_x_s[DATA_WIDTH-1:0] = own_d;
        oth_x_s[DATA_WIDTH-1:0] = oth_d;
        own_sel_x_s[NL-1:0]     = own_sel;
        oth_sel_x_s[NL-1:0]     = oth_sel;
        merged_x_s = lane_merge(lane_merge(old_x_s, own_x_s, own_sel_x_s),
                                oth_x_s, oth_sel_x_s);
        if (RDW_NEW != 0) begin
            data_s = merged_x_s[DATA_WIDTH-1:0];
        end else begin
            data_s = rd_word;
        end
    end

    // Stage-1 next state: capture on enable, hold otherwise.
    always_comb begin
        q1_d = q1_q;
        v1_d = 1'b0;
        if (rst) begin
            q1_d = '0;
            v1_d = 1'b0;
        end else begin
            v1_d = en;
            if (en) begin
                q1_d = data_s;
            end else begin
                q1_d = q1_q;
            end
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk) begin
        q1_q <= q1_d;
        v1_q <= v1_d;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q2_d, q2_q;
            logic                  v2_d, v2_q;

            // Stage-2 follows stage-1 every cycle; reset discards in-flight reads.
            always_comb begin
                q2_d = q1_q;
                v2_d = v1_q;
                if (rst) begin
                    q2_d = '0;
                    v2_d = 1'b0;
                end else begin
                    q2_d = q1_q;
                    v2_d = v1_q;
                end
            end

            // Stage-2 registers.
            always_ff @(posedge clk) begin
                q2_q <= q2_d;
                v2_q <= v2_d;
            end

            assign q   = q2_q;
            assign vld = v2_q;
        end else begin : g_no_out_reg
            assign q   = q1_q;
            assign vld = v1_q;
        end
    endgenerate

endmodule

// File: rtl/ram_wb_dp_be.sv
// True dual-port byte-enable RAM: storage array, write arbitration and collision flag.
module ram_wb_dp_be
    import ram_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int MEM_SIZE   = 2048,
    parameter int RDW_NEW    = 0,
    parameter int OUT_REG    = 0,
    parameter int PRIO_B     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_a,
    input  logic                          we_a,
    input  logic [lanes(DATA_WIDTH)-1:0]  sel_a,
    input  logic [ADDR_WIDTH-1:0]         adr_a,
    input  logic [DATA_WIDTH-1:0]         d_a,
    output logic [DATA_WIDTH-1:0]         q_a,
    output logic                          vld_a,
    input  logic                          en_b,
    input  logic                          we_b,
    input  logic [lanes(DATA_WIDTH)-1:0]  sel_b,
    input  logic [ADDR_WIDTH-1:0]         adr_b,
    input  logic [DATA_WIDTH-1:0]         d_b,
    output logic [DATA_WIDTH-1:0]         q_b,
    output logic                          vld_b,
    output logic                          coll
);

    localparam int NL    = lanes(DATA_WIDTH);
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_SIZE_W = MEM_SIZE[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

    logic            in_rng_a_s, in_rng_b_s, same_adr_s;
    logic            wr_a_s, wr_b_s;
    logic [IDX_W-1:0] idx_a_s, idx_b_s;
    logic [NL-1:0]   base_a_s, base_b_s, wsel_a_s, wsel_b_s;
    logic [NL-1:0]   fwd_b2a_s, fwd_a2b_s;
    logic [DATA_WIDTH-1:0] rd_a_s, rd_b_s;
    logic            coll_d, coll_q;

    assign idx_a_s = adr_a[IDX_W-1:0];
    assign idx_b_s = adr_b[IDX_W-1:0];

    // Write qualification and lane arbitration; losing lanes are masked off the loser.
    always_comb begin
        in_rng_a_s = ({1'b0, adr_a} < MEM_SIZE_W);
        in_rng_b_s = ({1'b0, adr_b} < MEM_SIZE_W);
        same_adr_s = (adr_a == adr_b);
        wr_a_s     = en_a & we_a & in_rng_a_s & ~rst;
        wr_b_s     = en_b & we_b & in_rng_b_s & ~rst;
        base_a_s   = wr_a_s ? sel_a : '0;
        base_b_s   = wr_b_s ? sel_b : '0;
        if (PRIO_B != 0) begin
            wsel_a_s = base_a_s & ~(same_adr_s ? base_b_s : '0);
            wsel_b_s = base_b_s;
        end else begin
            wsel_a_s = base_a_s;
            wsel_b_s = base_b_s & ~(same_adr_s ? base_a_s : '0);
        end
        fwd_b2a_s = same_adr_s ? wsel_b_s : '0;
        fwd_a2b_s = same_adr_s ? wsel_a_s : '0;
    end

    // Old-word read; out-of-range addresses read as zero.
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        if (in_rng_a_s) begin
            rd_a_s = mem_q[idx_a_s];
        end else begin
            rd_a_s = '0;
        end
        if (in_rng_b_s) begin
            rd_b_s = mem_q[idx_b_s];
        end else begin
            rd_b_s = '0;
        end
    end

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (wsel_a_s[i]) mem_q[idx_a_s][i*BYTE_W +: BYTE_W] <= d_a[i*BYTE_W +: BYTE_W];
            if (wsel_b_s[i]) mem_q[idx_b_s][i*BYTE_W +: BYTE_W] <= d_b[i*BYTE_W +: BYTE_W];
        end
    end

    // Collision: both ports write the same in-range word with overlapping lanes.
    always_comb begin
        coll_d = 1'b0;
        if (rst) begin
            coll_d = 1'b0;
        end else begin
            coll_d = wr_a_s & wr_b_s & same_adr_s & (|(sel_a & sel_b));
        end
    end

    // Collision pulse register.
    always_ff @(posedge clk) begin
        coll_q <= coll_d;
    end

    assign coll = coll_q;

    ram_wb_dp_be_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .RDW_NEW    (RDW_NEW),
        .OUT_REG    (OUT_REG)
    ) u_port_a (
        .clk     (clk),
        .rst     (rst),
        .en      (en_a),
        .rd_word (rd_a_s),
        .own_d   (d_a),
        .own_sel (wsel_a_s),
        .oth_d   (d_b),
        .oth_sel (fwd_b2a_s),
        .q       (q_a),
        .vld     (vld_a)
    );

    ram_wb_dp_be_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .RDW_NEW    (RDW_NEW),
        .OUT_REG    (OUT_REG)
    ) u_port_b (
        .clk     (clk),
        .rst     (rst),
        .en      (en_b),
        .rd_word (rd_b_s),
        .own_d   (d_b),
        .own_sel (wsel_b_s),
        .oth_d   (d_a),
        .oth_sel (fwd_a2b_s),
        .q       (q_b),
        .vld     (vld_b)
    );

endmodule

// File: tb/tb_ram_wb_dp_be.sv
// Directed bench: dut0 = defaults (old-data RDW, no out reg, A wins, 2048 words);
// dut1 = new-data RDW, output register, B wins, 1000 words. Same stimulus to both.
module tb_ram_wb_dp_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  sel_a, sel_b;
    logic [10:0] adr_a, adr_b;
    logic [31:0] d_a, d_b;

    logic [31:0] q0_a, q0_b, q1_a, q1_b;
    logic        v0_a, v0_b, v1_a, v1_b, c0, c1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_wb_dp_be dut0 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .sel_a(sel_a), .adr_a(adr_a), .d_a(d_a), .q_a(q0_a), .vld_a(v0_a),
        .en_b(en_b), .we_b(we_b), .sel_b(sel_b), .adr_b(adr_b), .d_b(d_b), .q_b(q0_b), .vld_b(v0_b),
        .coll(c0)
    );

    ram_wb_dp_be #(
        .MEM_SIZE(1000), .RDW_NEW(1), .OUT_REG(1), .PRIO_B(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .sel_a(sel_a), .adr_a(adr_a), .d_a(d_a), .q_a(q1_a), .vld_a(v1_a),
        .en_b(en_b), .we_b(we_b), .sel_b(sel_b), .adr_b(adr_b), .d_b(d_b), .q_b(q1_b), .vld_b(v1_b),
        .coll(c1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ea, input logic wa, input logic [3:0] sa,
                         input logic [10:0] aa, input logic [31:0] da,
                         input logic eb, input logic wb, input logic [3:0] sb,
                         input logic [10:0] ab, input logic [31:0] db);
        en_a = ea; we_a = wa; sel_a = sa; adr_a = aa; d_a = da;
        en_b = eb; we_b = wb; sel_b = sb; adr_b = ab; d_b = db;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 11'd0, 32'h0, 1'b0, 1'b0, 4'h0, 11'd0, 32'h0);
    endtask

    // Port A write then flush both pipelines.
    task automatic wr_a(input logic [10:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        drive(1'b1, 1'b1, sel, adr, dat, 1'b0, 1'b0, 4'h0, 11'd0, 32'h0);
        tick();
        idle();
        tick();
        tick();
    endtask

    // Read through one port; dut0 answers after 1 cycle, dut1 after 2.
    task automatic rd_chk(input string tag, input logic port_b, input logic [10:0] adr,
                          input logic [31:0] exp0, input logic [31:0] exp1);
        if (port_b) drive(1'b0, 1'b0, 4'h0, 11'd0, 32'h0, 1'b1, 1'b0, 4'h0, adr, 32'h0);
        else        drive(1'b1, 1'b0, 4'h0, adr, 32'h0, 1'b0, 1'b0, 4'h0, 11'd0, 32'h0);
        tick();
        idle();
        check({tag, "_q0"},   port_b ? q0_b : q0_a, exp0);
        check({tag, "_v0"},   32'(port_b ? v0_b : v0_a), 32'd1);
        check({tag, "_v1e"},  32'(port_b ? v1_b : v1_a), 32'd0);
        tick();
        check({tag, "_q1"},   port_b ? q1_b : q1_a, exp1);
        check({tag, "_v1"},   32'(port_b ? v1_b : v1_a), 32'd1);
        check({tag, "_q0h"},  port_b ? q0_b : q0_a, exp0);
        check({tag, "_v0l"},  32'(port_b ? v0_b : v0_a), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // Reset with a pending read of address 5.
        drive(1'b1, 1'b0, 4'h0, 11'd5, 32'h0, 1'b0, 1'b0, 4'h0, 11'd0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_q0a", q0_a, 32'h0);
            check("rst_v0a", 32'(v0_a), 32'd0);
            check("rst_q1a", q1_a, 32'h0);
            check("rst_v1a", 32'(v1_a), 32'd0);
            check("rst_c0",  32'(c0), 32'd0);
        end
        // Write presented with rst=1 must not commit: preload 5, then try to overwrite in reset.
        rst = 1'b0;
        wr_a(11'd5, 32'hDEADBEEF, 4'hF);
        rst = 1'b1;
        wr_a(11'd5, 32'h01020304, 4'hF);
        rst = 1'b0;
        tick();
        rd_chk("rd5", 1'b0, 11'd5, 32'hDEADBEEF, 32'hDEADBEEF);

        // Byte-lane write.
        wr_a(11'd7, 32'h11223344, 4'hF);
        wr_a(11'd7, 32'hAABBCCDD, 4'b0101);
        rd_chk("lane7", 1'b0, 11'd7, 32'h11BB33DD, 32'h11BB33DD);

        // Read-during-write, same port (A) and cross port (B).
        wr_a(11'd3, 32'h0, 4'hF);
        drive(1'b1, 1'b1, 4'hF, 11'd3, 32'h12345678, 1'b1, 1'b0, 4'h0, 11'd3, 32'h0);
        tick();
        idle();
        check("rdw_q0b", q0_b, 32'h00000000);
        check("rdw_v0b", 32'(v0_b), 32'd1);
        check("rdw_q0a", q0_a, 32'h00000000);
        tick();
        check("rdw_q1b", q1_b, 32'h12345678);
        check("rdw_q1a", q1_a, 32'h12345678);
        tick();
        rd_chk("rdw_after", 1'b1, 11'd3, 32'h12345678, 32'h12345678);

        // Write-write collision with overlapping lane 1.
        wr_a(11'd9, 32'h0, 4'hF);
        drive(1'b1, 1'b1, 4'b0011, 11'd9, 32'hAAAAAAAA, 1'b1, 1'b1, 4'b0110, 11'd9, 32'hBBBBBBBB);
        tick();
        idle();
        check("coll0_hi", 32'(c0), 32'd1);
        check("coll1_hi", 32'(c1), 32'd1);
        tick();
        check("coll0_lo", 32'(c0), 32'd0);
        check("coll1_lo", 32'(c1), 32'd0);
        check("coll_q1a", q1_a, 32'h00BBBBAA);
        check("coll_q1b", q1_b, 32'h00BBBBAA);
        tick();
        rd_chk("coll9", 1'b0, 11'd9, 32'h00BBAAAA, 32'h00BBBBAA);

        // Non-overlapping same-address writes: no collision.
        drive(1'b1, 1'b1, 4'b0011, 11'd9, 32'hAAAAAAAA, 1'b1, 1'b1, 4'b1100, 11'd9, 32'hBBBBBBBB);
        tick();
        idle();
        check("nocoll0", 32'(c0), 32'd0);
        check("nocoll1", 32'(c1), 32'd0);
        tick();
        check("nocoll_q1b", q1_b, 32'hBBBBAAAA);
        tick();
        rd_chk("merge9", 1'b1, 11'd9, 32'hBBBBAAAA, 32'hBBBBAAAA);

        // Out of range for dut1 (1000 words), in range for dut0; no aliasing onto 476.
        wr_a(11'd476, 32'h0476CAFE, 4'hF);
        wr_a(11'd1500, 32'hFFFFFFFF, 4'hF);
        rd_chk("oor1500", 1'b0, 11'd1500, 32'hFFFFFFFF, 32'h00000000);
        rd_chk("alias476", 1'b0, 11'd476, 32'h0476CAFE, 32'h0476CAFE);

        // Reset mid-stream: the read of address 2 is discarded.
        wr_a(11'd1, 32'h00000111, 4'hF);
        wr_a(11'd2, 32'h00000222, 4'hF);
        drive(1'b1, 1'b0, 4'h0, 11'd1, 32'h0, 1'b0, 1'b0, 4'h0, 11'd0, 32'h0);
        tick();
        check("ms_q0a1", q0_a, 32'h00000111);
        drive(1'b1, 1'b0, 4'h0, 11'd2, 32'h0, 1'b0, 1'b0, 4'h0, 11'd0, 32'h0);
        tick();
        check("ms_q0a2", q0_a, 32'h00000222);
        check("ms_q1a1", q1_a, 32'h00000111);
        check("ms_v1a1", 32'(v1_a), 32'd1);
        idle();
        rst = 1'b1;
        tick();
        check("ms_v1a_rst", 32'(v1_a), 32'd0);
        check("ms_q1a_rst", q1_a, 32'h0);
        check("ms_v0a_rst", 32'(v0_a), 32'd0);
        rst = 1'b0;
        tick();
        check("ms_v1a_post", 32'(v1_a), 32'd0);
        rd_chk("ms_resume", 1'b0, 11'd2, 32'h00000222, 32'h00000222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
